axi4_burst_master: RTL and testbench
====================================

# axi4_burst_master

Single-outstanding AXI4 burst master that serves the instruction- and data-cache refill and write-back requests issued by the control unit. It converts a read-start edge into one INCR read burst of a full cache block, streaming each beat to the cache. It converts a write-start edge into one INCR write burst from a block-wide write buffer. It returns the completion pulses the cache FSMs wait on: last read beat, and write response.

## Interface
- BLOCK_WORDS, 16: 32-bit words per cache block; power of two, 2..256.
- ADDR_WIDTH, 64: AXI address width.
- clk  in  1  clock; all logic rising-edge.
- arstn  in  1  asynchronous active-low reset.
- i_start_read  in  1  refill request; rising edge starts a read burst.
- i_start_write  in  1  write-back request; rising edge starts a write burst.
- i_addr  in  ADDR_WIDTH  block address; low log2(BLOCK_WORDS*4) bits are forced to 0.
- i_wdata_block  in  32*BLOCK_WORDS  write-back block; word k at bits [32k+31:32k].
- o_rdata  out  32  current read beat.
- o_rdata_valid  out  1  o_rdata holds an accepted beat this cycle.
- o_read_last  out  1  one-cycle pulse on the final accepted read beat.
- o_b_resp  out  1  one-cycle pulse on B handshake.
- o_err  out  1  sticky flag for SLVERR/DECERR or an rlast mismatch; cleared only by reset.
- AR channel: o_ar_valid out 1, i_ar_ready in 1, o_ar_addr out ADDR_WIDTH, o_ar_len out 8 (=BLOCK_WORDS-1), o_ar_size out 3 (=3'b010), o_ar_burst out 2 (=2'b01).
- R channel: i_r_valid in 1, o_r_ready out 1, i_r_data in 32, i_r_last in 1, i_r_resp in 2.
- AW channel: o_aw_valid, i_aw_ready, o_aw_addr, o_aw_len, o_aw_size, o_aw_burst; same widths and values as AR.
- W channel: o_w_valid out 1, i_w_ready in 1, o_w_data out 32, o_w_strb out 4 (=4'hF), o_w_last out 1.
- B channel: i_b_valid in 1, o_b_ready out 1, i_b_resp in 2.

## Operation
- States: IDLE, AR, R, AW, W, B.
- Start detection:
  - Edges are detected from registered copies of i_start_read and i_start_write, which reset to 0.
  - Edges are only acted on in IDLE. Edges arriving in any other state are dropped.
- IDLE transitions:
  - On a write edge: latch the aligned address and i_wdata_block into internal registers, then go to AW.
  - Otherwise, on a read edge: latch the aligned address, then go to AR.
  - If both edges occur in the same cycle, write wins and the read edge is lost. The cache FSM issues write-back before refill, so this does not occur in normal operation.
- AR state:
  - o_ar_valid=1 with o_ar_addr taken from the latched address.
  - On ar_valid&ar_ready, go to R and clear the beat counter.
- R state:
  - o_r_ready=1. Each r_valid&r_ready registers i_r_data into o_rdata, pulses o_rdata_valid, and increments the counter.
  - On the beat where counter==BLOCK_WORDS-1: pulse o_read_last and go to IDLE.
  - i_r_last must equal (counter==BLOCK_WORDS-1); any mismatch sets o_err. Completion is always counter-based.
  - A non-zero i_r_resp sets o_err. The beat is still delivered.
- AW state: same as AR, then go to W with the counter cleared.
- W state:
  - o_w_valid=1. o_w_data is the buffer word selected by the counter. o_w_last=(counter==BLOCK_WORDS-1).
  - The counter advances on w_valid&w_ready. After the last beat, go to B.
- B state:
  - o_b_ready=1. On b_valid: pulse o_b_resp and go to IDLE.
  - A non-zero i_b_resp sets o_err.
- Counter width is log2(BLOCK_WORDS). It never wraps within a burst because the exit is taken at BLOCK_WORDS-1.

## Timing
- Reset (arstn=0, asynchronous):
  - State goes to IDLE; counter, latched address, write buffer, edge registers, and o_err go to 0.
  - All valid/ready/pulse outputs go to 0; o_rdata goes to 0.
  - Reset mid-burst abandons the transaction without completing the AXI handshake. The interconnect must be reset by the same arstn.
- Constant AXI fields (len, size, burst, strb) are driven constantly, including during reset.
- Read path latency:
  - Start edge at cycle N puts o_ar_valid high at N+2 (one cycle of edge register, one cycle of state update).
  - An R handshake at cycle M gives o_rdata/o_rdata_valid at M+1, and o_read_last at M+1 for the final beat.
- Write path latency:
  - o_aw_valid goes high at N+2.
  - The first W beat is offered the cycle after the AW handshake.
  - o_b_resp pulses the cycle after the B handshake.
- Valid behaviour: every valid stays high until its handshake, and payloads remain stable while stalled.
- o_r_ready and o_b_ready are state-decoded combinationally. All other outputs are registered.
- Back-to-back: the earliest a new edge is accepted is the cycle the state returns to IDLE.
- Throughput: one beat per cycle with ready/valid held high.

## Test plan
- Read, BLOCK_WORDS=16, i_addr=0x1234 -> o_ar_addr=0x1200 and o_ar_len=15. Slave returns 0xA0..0xAF, one per cycle -> 16 o_rdata_valid pulses with matching data, and o_read_last coincides with 0xAF.
- Write with a block of words 0x100+k, and i_w_ready toggling every other cycle -> o_w_data sequence 0x100..0x10F with no drops or repeats, o_w_last only on 0x10F, and o_b_resp one cycle after b_valid.
- i_start_write and i_start_read rise in the same cycle -> AW burst only, then return to IDLE with no AR issued. Holding start high afterwards does not retrigger.
- Slave asserts i_r_last on beat 7, or returns i_r_resp=2'b10 -> o_err=1 and stays 1. The burst still completes after 16 beats.
- arstn pulsed low during R beat 5 -> all outputs go to 0 immediately. A fresh read edge after release runs a full 16-beat burst correctly.
- Random ar_ready/aw_ready/r_valid/b_valid delays of 0..5 cycles over 200 mixed bursts -> data matches a scoreboard, and exactly one completion pulse is produced per start edge.

Source files
------------

// File: rtl/axi4_burst_master.sv
// ---------------------------------------------------------------------------
// axi4_burst_master
//
// Single-outstanding AXI4 master serving cache refills and write-backs.
// A rising edge on i_start_read issues one INCR read burst of a full cache
// block and streams every accepted beat out on o_rdata/o_rdata_valid. A
// rising edge on i_start_write issues one INCR write burst from a block-wide
// buffer captured at the start. Completion is reported by o_read_last (final
// read beat) and o_b_resp (write response).
//
// Handshake rule on every AXI channel: a transfer happens on a rising clk
// edge where valid and ready are both high; a valid, once raised, stays high
// with a stable payload until that edge.
//
// Ports:
//   clk, arstn            clock, asynchronous active-low reset
//   i_start_read/write    refill / write-back requests (edge triggered)
//   i_addr                block address (low offset bits ignored)
//   i_wdata_block         write-back block, word k at [32k+31:32k]
//   o_rdata, o_rdata_valid, o_read_last   read beat stream to the cache
//   o_b_resp              write completion pulse
//   o_err                 sticky error (bad resp or rlast mismatch)
//   o_ar_*, i_r_*, o_r_ready, o_aw_*, o_w_*, i_w_ready, i_b_*, o_b_ready
//                         AXI4 master channels
//   o_dbg_state           current FSM state for observation
// ---------------------------------------------------------------------------
module axi4_burst_master #(
   parameter int BLOCK_WORDS = 16,
   parameter int ADDR_WIDTH  = 64
) (
   input  logic                      clk,
   input  logic                      arstn,
   input  logic                      i_start_read,
   input  logic                      i_start_write,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   input  logic [32*BLOCK_WORDS-1:0] i_wdata_block,
   output logic [31:0]               o_rdata,
   output logic                      o_rdata_valid,
   output logic                      o_read_last,
   output logic                      o_b_resp,
   output logic                      o_err,
   // AR channel
   output logic                      o_ar_valid,
   input  logic                      i_ar_ready,
   output logic [ADDR_WIDTH-1:0]     o_ar_addr,
   output logic [7:0]                o_ar_len,
   output logic [2:0]                o_ar_size,
   output logic [1:0]                o_ar_burst,
   // R channel
   input  logic                      i_r_valid,
   output logic                      o_r_ready,
   input  logic [31:0]               i_r_data,
   input  logic                      i_r_last,
   input  logic [1:0]                i_r_resp,
   // AW channel
   output logic                      o_aw_valid,
   input  logic                      i_aw_ready,
   output logic [ADDR_WIDTH-1:0]     o_aw_addr,
   output logic [7:0]                o_aw_len,
   output logic [2:0]                o_aw_size,
   output logic [1:0]                o_aw_burst,
   // W channel
   output logic                      o_w_valid,
   input  logic                      i_w_ready,
   output logic [31:0]               o_w_data,
   output logic [3:0]                o_w_strb,
   output logic                      o_w_last,
   // B channel
   input  logic                      i_b_valid,
   output logic                      o_b_ready,
   input  logic [1:0]                i_b_resp,
   // Observation
   output logic [2:0]                o_dbg_state
);

   localparam int CW = $clog2(BLOCK_WORDS);
   localparam logic [CW-1:0]         LAST     = CW'(BLOCK_WORDS - 1);
   localparam logic [7:0]            BURST_LEN = 8'(BLOCK_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BLOCK_WORDS * 4 - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AW   = 3'd3,
      S_W    = 3'd4,
      S_B    = 3'd5
   } state_e;

   state_e                    state_q, state_d;
   logic                      rd_cur_q, rd_prev_q;
   logic                      wr_cur_q, wr_prev_q;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [32*BLOCK_WORDS-1:0] wbuf_q, wbuf_d;
   logic                      err_q, err_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      rdata_valid_q, rdata_valid_d;
   logic                      read_last_q, read_last_d;
   logic                      b_resp_q, b_resp_d;
   logic                      ar_valid_q, ar_valid_d;
   logic                      aw_valid_q, aw_valid_d;
   logic                      w_valid_q, w_valid_d;
   logic [31:0]               w_data_q, w_data_d;
   logic                      w_last_q, w_last_d;

   logic rd_edge, wr_edge, cnt_is_last;

   // Edges come from the registered copies, so a start held high only
   // fires once and an edge is seen one cycle after the input rises.
   assign rd_edge     = rd_cur_q & ~rd_prev_q;
   assign wr_edge     = wr_cur_q & ~wr_prev_q;
   assign cnt_is_last = (cnt_q == LAST);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q       <= S_IDLE;
         rd_cur_q      <= 1'b0;
         rd_prev_q     <= 1'b0;
         wr_cur_q      <= 1'b0;
         wr_prev_q     <= 1'b0;
         cnt_q         <= '0;
         addr_q        <= '0;
         wbuf_q        <= '0;
         err_q         <= 1'b0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         read_last_q   <= 1'b0;
         b_resp_q      <= 1'b0;
         ar_valid_q    <= 1'b0;
         aw_valid_q    <= 1'b0;
         w_valid_q     <= 1'b0;
         w_data_q      <= '0;
         w_last_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_cur_q      <= i_start_read;
         rd_prev_q     <= rd_cur_q;
         wr_cur_q      <= i_start_write;
         wr_prev_q     <= wr_cur_q;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         wbuf_q        <= wbuf_d;
         err_q         <= err_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         read_last_q   <= read_last_d;
         b_resp_q      <= b_resp_d;
         ar_valid_q    <= ar_valid_d;
         aw_valid_q    <= aw_valid_d;
         w_valid_q     <= w_valid_d;
         w_data_q      <= w_data_d;
         w_last_q      <= w_last_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      wbuf_d        = wbuf_q;
      err_d         = err_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      read_last_d   = 1'b0;
      b_resp_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Write-back takes priority; a simultaneous read edge is lost.
            if (wr_edge) begin
               addr_d  = i_addr & ~OFF_MASK;
               wbuf_d  = i_wdata_block;
               state_d = S_AW;
            end else if (rd_edge) begin
               addr_d  = i_addr & ~OFF_MASK;
               state_d = S_AR;
            end
         end
         S_AR: begin
            if (ar_valid_q && i_ar_ready) begin
               state_d = S_R;
               cnt_d   = '0;
            end
         end
         S_R: begin
            if (i_r_valid) begin
               rdata_d       = i_r_data;
               rdata_valid_d = 1'b1;
               // Completion follows our own count; a slave rlast that
               // disagrees is only flagged.
               if (i_r_last != cnt_is_last) err_d = 1'b1;
               if (i_r_resp != 2'b00)       err_d = 1'b1;
               if (cnt_is_last) begin
                  read_last_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_AW: begin
            if (aw_valid_q && i_aw_ready) begin
               state_d = S_W;
               cnt_d   = '0;
            end
         end
         S_W: begin
            if (w_valid_q && i_w_ready) begin
               if (cnt_is_last) state_d = S_B;
               else             cnt_d   = cnt_q + CW'(1);
            end
         end
         S_B: begin
            if (i_b_valid) begin
               b_resp_d = 1'b1;
               if (i_b_resp != 2'b00) err_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered channel outputs are computed from the next state so they
      // line up with it; the W payload follows the next counter value and
      // therefore holds still while the slave stalls.
      ar_valid_d = (state_d == S_AR);
      aw_valid_d = (state_d == S_AW);
      w_valid_d  = (state_d == S_W);
      w_data_d   = wbuf_d[{cnt_d, 5'd0} +: 32];
      w_last_d   = (state_d == S_W) && (cnt_d == LAST);
   end

   assign o_rdata       = rdata_q;
   assign o_rdata_valid = rdata_valid_q;
   assign o_read_last   = read_last_q;
   assign o_b_resp      = b_resp_q;
   assign o_err         = err_q;

   assign o_ar_valid = ar_valid_q;
   assign o_ar_addr  = addr_q;
   assign o_ar_len   = BURST_LEN;
   assign o_ar_size  = 3'b010;
   assign o_ar_burst = 2'b01;

   assign o_r_ready  = (state_q == S_R);

   assign o_aw_valid = aw_valid_q;
   assign o_aw_addr  = addr_q;
   assign o_aw_len   = BURST_LEN;
   assign o_aw_size  = 3'b010;
   assign o_aw_burst = 2'b01;

   assign o_w_valid  = w_valid_q;
   assign o_w_data   = w_data_q;
   assign o_w_strb   = 4'hF;
   assign o_w_last   = w_last_q;

   assign o_b_ready  = (state_q == S_B);

   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_axi4_burst_master.sv
module tb_axi4_burst_master;

   localparam int BW = 16;
   localparam int AW = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              arstn;
   logic              i_start_read, i_start_write;
   logic [AW-1:0]     i_addr;
   logic [32*BW-1:0]  i_wdata_block;
   logic [31:0]       o_rdata;
   logic              o_rdata_valid, o_read_last, o_b_resp, o_err;
   logic              o_ar_valid, i_ar_ready;
   logic [AW-1:0]     o_ar_addr;
   logic [7:0]        o_ar_len;
   logic [2:0]        o_ar_size;
   logic [1:0]        o_ar_burst;
   logic              i_r_valid, o_r_ready;
   logic [31:0]       i_r_data;
   logic              i_r_last;
   logic [1:0]        i_r_resp;
   logic              o_aw_valid, i_aw_ready;
   logic [AW-1:0]     o_aw_addr;
   logic [7:0]        o_aw_len;
   logic [2:0]        o_aw_size;
   logic [1:0]        o_aw_burst;
   logic              o_w_valid, i_w_ready;
   logic [31:0]       o_w_data;
   logic [3:0]        o_w_strb;
   logic              o_w_last;
   logic              i_b_valid, o_b_ready;
   logic [1:0]        i_b_resp;
   logic [2:0]        o_dbg_state;

   axi4_burst_master #(.BLOCK_WORDS(BW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .arstn(arstn),
      .i_start_read(i_start_read), .i_start_write(i_start_write),
      .i_addr(i_addr), .i_wdata_block(i_wdata_block),
      .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
      .o_read_last(o_read_last), .o_b_resp(o_b_resp), .o_err(o_err),
      .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr),
      .o_ar_len(o_ar_len), .o_ar_size(o_ar_size), .o_ar_burst(o_ar_burst),
      .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .i_r_data(i_r_data),
      .i_r_last(i_r_last), .i_r_resp(i_r_resp),
      .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr),
      .o_aw_len(o_aw_len), .o_aw_size(o_aw_size), .o_aw_burst(o_aw_burst),
      .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data),
      .o_w_strb(o_w_strb), .o_w_last(o_w_last),
      .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_resp(i_b_resp),
      .o_dbg_state(o_dbg_state)
   );

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   logic [31:0] exp_rd_q[$];
   logic        exp_rl_q[$];
   logic [31:0] exp_w_q[$];
   logic        exp_wl_q[$];
   logic [31:0] got_rd_q[$];
   logic        got_rl_q[$];
   logic [31:0] got_w_q[$];
   logic        got_wl_q[$];
   logic        exp_err;
   int          exp_rlast_cnt = 0;
   int          exp_bresp_cnt = 0;

   // Slave behaviour knobs
   int          max_dly       = 0;
   int          bad_last_beat = -1;
   int          bad_resp_beat = -1;
   logic [1:0]  bresp_val     = 2'b00;
   int          abort_after   = -1;
   int          wready_mode   = 0;   // 0 always, 1 toggle, 2 random
   int          dir_base      = -1;

   // ---------------- output monitor (negedge) ----------------
   int rlast_cnt  = 0;
   int bresp_cnt  = 0;
   int ar_cycles  = 0;
   int stray_last = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (o_rdata_valid) begin
            got_rd_q.push_back(o_rdata);
            got_rl_q.push_back(o_read_last);
         end else if (o_read_last) begin
            stray_last++;
         end
         if (o_read_last) rlast_cnt++;
         if (o_b_resp)    bresp_cnt++;
         if (o_ar_valid)  ar_cycles++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int dly();
      return (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
   endfunction

   function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
      return a & ~64'(BW * 4 - 1);
   endfunction

   task automatic clear_queues();
      exp_rd_q.delete(); exp_rl_q.delete(); got_rd_q.delete(); got_rl_q.delete();
      exp_w_q.delete();  exp_wl_q.delete(); got_w_q.delete();  got_wl_q.delete();
   endtask

   task automatic idle_inputs();
      i_start_read = 0; i_start_write = 0;
      i_ar_ready = 0; i_aw_ready = 0; i_w_ready = 0;
      i_r_valid = 0; i_r_data = '0; i_r_last = 0; i_r_resp = 2'b00;
      i_b_valid = 0; i_b_resp = 2'b00;
   endtask

   task automatic apply_reset();
      arstn = 1'b0;
      idle_inputs();
      repeat (2) tick();
      arstn = 1'b1;
      tick();
      exp_err = 1'b0;
      clear_queues();
   endtask

   task automatic slave_read(input logic [AW-1:0] exp_addr);
      int t;
      logic [31:0] d;
      t = 0;
      while (!o_ar_valid && t < 100) begin tick(); t++; end
      check("ar_seen", 64'(o_ar_valid), 64'd1);
      if (!o_ar_valid) return;
      check("ar_addr", 64'(o_ar_addr), 64'(exp_addr));
      repeat (dly()) tick();
      i_ar_ready = 1'b1;
      tick();
      i_ar_ready = 1'b0;
      for (int k = 0; k < BW; k++) begin
         d = (dir_base >= 0) ? 32'(dir_base + k) : $urandom;
         repeat (dly()) tick();
         i_r_valid = 1'b1;
         i_r_data  = d;
         i_r_last  = (k == BW - 1) || (k == bad_last_beat);
         i_r_resp  = (k == bad_resp_beat) ? 2'b10 : 2'b00;
         t = 0;
         while (!o_r_ready && t < 100) begin tick(); t++; end
         if (!o_r_ready) begin
            check("r_ready_timeout", 64'd0, 64'd1);
            i_r_valid = 1'b0;
            return;
         end
         tick();
         i_r_valid = 1'b0; i_r_last = 1'b0; i_r_resp = 2'b00;
         check("r_beat_data", 64'({o_rdata_valid, o_rdata}), 64'({1'b1, d}));
         exp_rd_q.push_back(d);
         exp_rl_q.push_back(k == BW - 1);
         if ((k == bad_last_beat && k != BW - 1) || k == bad_resp_beat) exp_err = 1'b1;
         if (k == abort_after) return;
      end
      exp_rlast_cnt++;
   endtask

   task automatic slave_write(input logic [AW-1:0] exp_addr);
      int   t, n;
      logic phase, hs, l;
      logic [31:0] d;
      t = 0;
      while (!o_aw_valid && t < 100) begin tick(); t++; end
      check("aw_seen", 64'(o_aw_valid), 64'd1);
      if (!o_aw_valid) return;
      check("aw_addr", 64'(o_aw_addr), 64'(exp_addr));
      repeat (dly()) tick();
      i_aw_ready = 1'b1;
      tick();
      i_aw_ready = 1'b0;
      check("w_first_offered", 64'(o_w_valid), 64'd1);
      n = 0; t = 0; phase = 1'b0;
      while (n < BW && t < 400) begin
         case (wready_mode)
            0:       i_w_ready = 1'b1;
            1:       begin i_w_ready = phase; phase = ~phase; end
            default: i_w_ready = 1'($urandom_range(1, 0));
         endcase
         hs = o_w_valid && i_w_ready;
         d  = o_w_data;
         l  = o_w_last;
         tick();
         t++;
         if (hs) begin
            got_w_q.push_back(d);
            got_wl_q.push_back(l);
            n++;
         end
      end
      i_w_ready = 1'b0;
      check("w_beats", 64'(n), 64'(BW));
      check("w_valid_after_last", 64'(o_w_valid), 64'd0);
      repeat (dly()) tick();
      i_b_valid = 1'b1;
      i_b_resp  = bresp_val;
      t = 0;
      while (!o_b_ready && t < 100) begin tick(); t++; end
      if (!o_b_ready) begin
         check("b_ready_timeout", 64'd0, 64'd1);
         i_b_valid = 1'b0;
         return;
      end
      tick();
      i_b_valid = 1'b0; i_b_resp = 2'b00;
      check("b_resp_pulse", 64'(o_b_resp), 64'd1);
      tick();
      check("b_resp_one_cycle", 64'(o_b_resp), 64'd0);
      if (bresp_val != 2'b00) exp_err = 1'b1;
      exp_bresp_cnt++;
   endtask

   task automatic do_read(input logic [AW-1:0] addr);
      i_addr = addr;
      i_start_read = 1'b1;
      tick();
      check("ar_latency_n1", 64'(o_ar_valid), 64'd0);
      i_start_read = 1'b0;
      tick();
      check("ar_latency_n2", 64'(o_ar_valid), 64'd1);
      slave_read(align(addr));
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [32*BW-1:0] blk);
      logic [32*BW-1:0] b;
      b = blk;
      i_addr = addr;
      i_wdata_block = blk;
      for (int k = 0; k < BW; k++) begin
         exp_w_q.push_back(b[32*k +: 32]);
         exp_wl_q.push_back(k == BW - 1);
      end
      i_start_write = 1'b1;
      tick();
      check("aw_latency_n1", 64'(o_aw_valid), 64'd0);
      i_start_write = 1'b0;
      tick();
      check("aw_latency_n2", 64'(o_aw_valid), 64'd1);
      slave_write(align(addr));
   endtask

   // ---------------- scoreboard ----------------
   task automatic compare_sb(input string tag);
      tick();   // lets the monitor sample the last beat
      check({tag, "_rd_count"}, 64'(got_rd_q.size()), 64'(exp_rd_q.size()));
      while (got_rd_q.size() > 0 && exp_rd_q.size() > 0) begin
         check({tag, "_rd_data"}, 64'(got_rd_q.pop_front()), 64'(exp_rd_q.pop_front()));
         check({tag, "_rd_last"}, 64'(got_rl_q.pop_front()), 64'(exp_rl_q.pop_front()));
      end
      check({tag, "_w_count"}, 64'(got_w_q.size()), 64'(exp_w_q.size()));
      while (got_w_q.size() > 0 && exp_w_q.size() > 0) begin
         check({tag, "_w_data"}, 64'(got_w_q.pop_front()), 64'(exp_w_q.pop_front()));
         check({tag, "_w_last"}, 64'(got_wl_q.pop_front()), 64'(exp_wl_q.pop_front()));
      end
      clear_queues();
      check({tag, "_read_last_cnt"}, 64'(rlast_cnt), 64'(exp_rlast_cnt));
      check({tag, "_b_resp_cnt"}, 64'(bresp_cnt), 64'(exp_bresp_cnt));
      check({tag, "_stray_last"}, 64'(stray_last), 64'd0);
      check({tag, "_err"}, 64'(o_err), 64'(exp_err));
   endtask

   function automatic logic [32*BW-1:0] rand_block();
      logic [32*BW-1:0] b;
      for (int k = 0; k < BW; k++) b[32*k +: 32] = $urandom;
      return b;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [32*BW-1:0] blk;
      int ar0;

      // Reset values, including the constant AXI fields during reset
      arstn = 1'b0;
      idle_inputs();
      i_addr = '0;
      i_wdata_block = '0;
      exp_err = 1'b0;
      #1;
      check("rst_outs", 64'({o_ar_valid, o_aw_valid, o_w_valid, o_w_last, o_r_ready,
                             o_b_ready, o_rdata_valid, o_read_last, o_b_resp, o_err}), 64'd0);
      check("rst_rdata", 64'(o_rdata), 64'd0);
      check("rst_const", 64'({o_ar_len, o_ar_size, o_ar_burst, o_aw_len, o_aw_size,
                              o_aw_burst, o_w_strb}),
                         64'({8'd15, 3'b010, 2'b01, 8'd15, 3'b010, 2'b01, 4'hF}));
      repeat (2) tick();
      arstn = 1'b1;
      tick();

      // Directed read: 0x1234 -> 0x1200, data 0xA0..0xAF
      dir_base = 32'hA0;
      do_read(64'h1234);
      dir_base = -1;
      compare_sb("dir_read");
      check("dir_ar_len", 64'(o_ar_len), 64'd15);

      // Directed write: words 0x100+k, w_ready toggling
      for (int k = 0; k < BW; k++) blk[32*k +: 32] = 32'h100 + 32'(k);
      wready_mode = 1;
      do_write(64'h8000_0047, blk);
      wready_mode = 0;
      compare_sb("dir_write");

      // Simultaneous starts: write wins, no AR, held starts do not retrigger
      blk = rand_block();
      i_addr = 64'h4_0080;
      i_wdata_block = blk;
      for (int k = 0; k < BW; k++) begin
         exp_w_q.push_back(blk[32*k +: 32]);
         exp_wl_q.push_back(k == BW - 1);
      end
      ar0 = ar_cycles;
      i_start_read = 1'b1;
      i_start_write = 1'b1;
      repeat (2) tick();
      check("both_aw", 64'(o_aw_valid), 64'd1);
      check("both_no_ar", 64'(o_ar_valid), 64'd0);
      slave_write(64'h4_0080);
      repeat (20) tick();
      check("both_no_ar_total", 64'(ar_cycles - ar0), 64'd0);
      check("both_no_retrigger", 64'({o_aw_valid, o_ar_valid}), 64'd0);
      i_start_read = 1'b0;
      i_start_write = 1'b0;
      compare_sb("both");

      // rlast asserted early on beat 7: sticky error, burst still 16 beats
      bad_last_beat = 7;
      do_read(64'h2000);
      bad_last_beat = -1;
      compare_sb("bad_rlast");
      repeat (5) tick();
      check("err_sticky", 64'(o_err), 64'd1);
      apply_reset();
      check("err_cleared", 64'(o_err), 64'd0);

      // SLVERR on a read beat
      bad_resp_beat = 3;
      do_read(64'h3040);
      bad_resp_beat = -1;
      compare_sb("bad_rresp");
      apply_reset();

      // Error response on B
      bresp_val = 2'b11;
      do_write(64'h5000, rand_block());
      bresp_val = 2'b00;
      compare_sb("bad_bresp");
      apply_reset();

      // Reset during read beat 5, then a fresh full burst
      abort_after = 5;
      do_read(64'h6000);
      abort_after = -1;
      #2;
      arstn = 1'b0;
      #1;
      check("midrst_outs", 64'({o_ar_valid, o_aw_valid, o_w_valid, o_w_last, o_r_ready,
                                o_b_ready, o_rdata_valid, o_read_last, o_b_resp, o_err}), 64'd0);
      check("midrst_rdata", 64'(o_rdata), 64'd0);
      tick();
      arstn = 1'b1;
      tick();
      clear_queues();
      do_read(64'h7000);
      compare_sb("after_midrst");

      // Randomized mixed bursts with slave delays of 0..5 cycles
      max_dly = 5;
      wready_mode = 2;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(1, 0) == 1) do_write({$urandom, $urandom}, rand_block());
         else                           do_read({$urandom, $urandom});
         compare_sb("rand");
         repeat ($urandom_range(3, 0)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
